// File: rtl/rcc_div_ratio_det_if.sv
// Bus bundle for the divider-ratio detector.
// Optional compare feature: define RCC_DIV_DET_CMP_EN to add exp_sel / det_mis.
interface rcc_div_ratio_det_if;
  logic       en;
  logic       div_en;
  logic [3:0] det_sel;
  logic       det_vld;
  logic       det_err;
`ifdef RCC_DIV_DET_CMP_EN
  logic [3:0] exp_sel;
  logic       det_mis;

  modport master (
    output en, div_en, exp_sel,
    input  det_sel, det_vld, det_err, det_mis
  );
  modport slave (
    input  en, div_en, exp_sel,
    output det_sel, det_vld, det_err, det_mis
  );
`else
  modport master (
    output en, div_en,
    input  det_sel, det_vld, det_err
  );
  modport slave (
    input  en, div_en,
    output det_sel, det_vld, det_err
  );
`endif
endinterface

// File: rtl/rcc_div_ratio_det.sv
// Divider ratio detector: measures the spacing of div_en pulses in i_clk
// cycles, maps legal periods to a divider select code and reports it once
// LOCK_CNT consecutive identical periods have been seen.
// Optional compare feature: define RCC_DIV_DET_CMP_EN to add exp_sel / det_mis.
module rcc_div_ratio_det #(
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic                i_clk,
  input  logic                rst,
  rcc_div_ratio_det_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_MEAS = 2'd2;
  localparam logic [1:0] ST_LOCK = 2'd3;

  localparam logic [9:0] CNT_MAX  = '1;
  localparam logic [2:0] LOCK_TGT = 3'(LOCK_CNT);

  logic [1:0] state, state_nxt;
  logic [9:0] cnt, cnt_nxt;
  logic [2:0] match, match_nxt;
  logic [3:0] cand, cand_nxt;
  logic [3:0] sel, sel_nxt;
  logic       vld, vld_nxt;
  logic       err, err_nxt;
  logic       legal;
  logic [3:0] code;

  // Period-to-code decode of the running counter (only meaningful on div_en)
  always_comb begin
    legal = 1'b1;
    code  = '0;
    case (cnt)
      10'd1:   code = 4'b0000;
      10'd2:   code = 4'b1000;
      10'd4:   code = 4'b1001;
      10'd8:   code = 4'b1010;
      10'd16:  code = 4'b1011;
      10'd64:  code = 4'b1100;
      10'd128: code = 4'b1101;
      10'd256: code = 4'b1110;
      10'd512: code = 4'b1111;
      default: legal = 1'b0;
    endcase
  end

  // Next-state logic for the measurement FSM, period counter and outputs.
  // Codes map one-to-one onto legal periods, so the candidate is kept as a
  // code rather than a raw period. An illegal period's terminating pulse
  // already serves as the arming pulse, so measurement resumes directly.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    match_nxt = match;
    cand_nxt  = cand;
    sel_nxt   = sel;
    vld_nxt   = vld;
    err_nxt   = 1'b0;

    if (bus.div_en)
      cnt_nxt = 10'd1;
    else if (cnt != CNT_MAX)
      cnt_nxt = cnt + 10'd1;

    if (!bus.en) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      match_nxt = '0;
      vld_nxt   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_nxt   = '0;
          state_nxt = ST_ARM;
        end
        ST_ARM: begin
          if (bus.div_en)
            state_nxt = ST_MEAS;
        end
        ST_MEAS, ST_LOCK: begin
          if (bus.div_en) begin
            if (!legal) begin
              err_nxt   = 1'b1;
              vld_nxt   = 1'b0;
              match_nxt = '0;
              state_nxt = ST_MEAS;
            end else if ((match != 3'd0) && (code == cand)) begin
              if (state == ST_MEAS) begin
                match_nxt = match + 3'd1;
                if ((match + 3'd1) == LOCK_TGT) begin
                  state_nxt = ST_LOCK;
                  sel_nxt   = cand;
                  vld_nxt   = 1'b1;
                end
              end
            end else begin
              match_nxt = 3'd1;
              cand_nxt  = code;
              if (state == ST_LOCK) begin
                vld_nxt   = 1'b0;
                state_nxt = ST_MEAS;
              end else if (LOCK_TGT == 3'd1) begin
                state_nxt = ST_LOCK;
                sel_nxt   = code;
                vld_nxt   = 1'b1;
              end
            end
          end else if (cnt == CNT_MAX) begin
            err_nxt   = 1'b1;
            vld_nxt   = 1'b0;
            match_nxt = '0;
            state_nxt = ST_ARM;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and output registers, asynchronously cleared by rst
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      match <= '0;
      cand  <= '0;
      sel   <= '0;
      vld   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      match <= match_nxt;
      cand  <= cand_nxt;
      sel   <= sel_nxt;
      vld   <= vld_nxt;
      err   <= err_nxt;
    end
  end

  assign bus.det_sel = sel;
  assign bus.det_vld = vld;
  assign bus.det_err = err;

`ifdef RCC_DIV_DET_CMP_EN
  logic mis;

  // Mismatch flag built from next-cycle lock state so it tracks det_vld exactly
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst)
      mis <= 1'b0;
    else
      mis <= vld_nxt & (sel_nxt != bus.exp_sel);
  end

  assign bus.det_mis = mis;
`endif

endmodule
